// File: rtl/multicycle_main_control.sv
// multicycle_main_control
//   Main control FSM for the multi-cycle MIPS-subset datapath. Walks each
//   instruction through FETCH/DECODE/EXEC/MEM/WB, waits on a variable-latency
//   memory through mem_ready, and falls into an absorbing TRAP state on an
//   illegal opcode or when memory stalls too long.
//
//   Ports
//     clk, rst        rising-edge clock, synchronous active-high reset
//     op              opcode field of the instruction register (valid from DECODE)
//     zero            ALU zero flag (valid in EXEC)
//     mem_ready       memory finished the current read/write this cycle
//     pc_write/pc_src PC load strobe and source (0 PC+4, 1 branch, 2 jump)
//     ir_write        instruction register load strobe
//     mem_read/write  memory request levels, held until mem_ready
//     i_or_d          memory address select (0 PC, 1 ALU result)
//     alu_src/alu_op  ALU B select and operation class
//     ext_op          1 sign-extend, 0 zero-extend immediate
//     reg_dst/reg_write/mem_to_reg  register file writeback controls
//     trap            sticky error flag
//     state           current state encoding (debug)
//     retired         completed-instruction counter, wraps
module multicycle_main_control #(
    parameter int OP_W        = 6,
    parameter int TIMEOUT_CYC = 16,
    parameter int RET_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             ext_op,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'('h00);
    localparam logic [OP_W-1:0] OP_J    = OP_W'('h02);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'('h04);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'('h05);
    localparam logic [OP_W-1:0] OP_ANDI = OP_W'('h0C);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'('h0D);
    localparam logic [OP_W-1:0] OP_XORI = OP_W'('h0E);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'('h23);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'('h2B);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t          st;
    logic [OP_W-1:0] op_q;
    logic [CNT_W-1:0] wait_cnt;

    function automatic logic is_legal(input logic [OP_W-1:0] o);
        return (o == OP_R) || (o == OP_J) || (o == OP_BEQ) || (o == OP_BNE) ||
               (o == OP_ANDI) || (o == OP_ORI) || (o == OP_XORI) ||
               (o == OP_LW) || (o == OP_SW);
    endfunction

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            trap     <= 1'b0;
            retired  <= '0;
        end else begin
            case (st)
                // FETCH and MEM share the stall/timeout handling; mem_ready on
                // the last allowed cycle still completes the access.
                S_FETCH: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        st       <= S_DECODE;
                    end else if (wait_cnt == CNT_LAST) begin
                        wait_cnt <= '0;
                        trap     <= 1'b1;
                        st       <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q <= op;
                    if (!is_legal(op)) begin
                        trap <= 1'b1;
                        st   <= S_TRAP;
                    end else if (op == OP_J) begin
                        retired <= retired + 1'b1;
                        st      <= S_FETCH;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R, OP_ANDI, OP_ORI, OP_XORI: st <= S_WB;
                        OP_LW, OP_SW:                   st <= S_MEM;
                        OP_BEQ, OP_BNE: begin
                            retired <= retired + 1'b1;
                            st      <= S_FETCH;
                        end
                        default: begin
                            trap <= 1'b1;
                            st   <= S_TRAP;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        if (op_q == OP_SW) begin
                            retired <= retired + 1'b1;
                            st      <= S_FETCH;
                        end else begin
                            st <= S_WB;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        wait_cnt <= '0;
                        trap     <= 1'b1;
                        st       <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    retired <= retired + 1'b1;
                    st      <= S_FETCH;
                end
                S_TRAP: st <= S_TRAP;
                // unused encodings are treated as a fault
                default: begin
                    trap <= 1'b1;
                    st   <= S_TRAP;
                end
            endcase
        end
    end

    // Strobes are decoded from the current state so memory handshakes and the
    // branch decision act in the same cycle; reset blanks them immediately.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        ext_op     = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        if (!rst) begin
            case (st)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    // op_q is not loaded yet, so the jump decision uses op directly
                    if (op == OP_J) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R: alu_op = 2'b10;
                        OP_ANDI, OP_ORI, OP_XORI: begin
                            alu_src = 1'b1;
                            alu_op  = 2'b11;
                        end
                        OP_LW, OP_SW: begin
                            alu_src = 1'b1;
                            ext_op  = 1'b1;
                        end
                        OP_BEQ, OP_BNE: begin
                            alu_op   = 2'b01;
                            pc_src   = 2'd1;
                            pc_write = (op_q == OP_BEQ) ? zero : ~zero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (op_q == OP_R);
                    mem_to_reg = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;
    localparam int T    = 16;
    localparam int RW   = 4;
    localparam int MAXC = 4096;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                           OP_LW = 6'h23, OP_SW = 6'h2B;

    // expected strobe vector bit masks
    localparam logic [14:0] PCW = 15'h4000, PCS1 = 15'h1000, PCS2 = 15'h2000,
                            IRW = 15'h0800, MRD = 15'h0400, MWR = 15'h0200,
                            IOD = 15'h0100, ASRC = 15'h0080, AOP1 = 15'h0020,
                            AOP2 = 15'h0040, AOP3 = 15'h0060, EXT = 15'h0010,
                            RDST = 15'h0008, RWR = 15'h0004, M2R = 15'h0002,
                            TRP = 15'h0001;

    logic clk = 1'b0;
    logic rst, zero, mem_ready;
    logic [5:0] op;
    logic pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src, ext_op;
    logic reg_dst, reg_write, mem_to_reg, trap;
    logic [1:0] pc_src, alu_op;
    logic [2:0] state;
    logic [RW-1:0] retired;

    multicycle_main_control #(.OP_W(6), .TIMEOUT_CYC(T), .RET_W(RW)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    wire [14:0] obs_vec = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
                           alu_src, alu_op, ext_op, reg_dst, reg_write, mem_to_reg, trap};

    int total = 0;
    int bad   = 0;

    // expected per-cycle trace, built from instruction-level rules
    logic [2:0]    exp_st [MAXC];
    logic [14:0]   exp_sb [MAXC];
    logic [RW-1:0] exp_ret[MAXC];
    logic          tr_mr  [MAXC];
    logic [5:0]    tr_op  [MAXC];
    logic          tr_z   [MAXC];
    logic [2:0]    obs_st [MAXC];
    logic [14:0]   obs_sb [MAXC];
    logic [RW-1:0] obs_ret[MAXC];
    int   n_cyc;
    int   ret_m;
    logic [5:0] cur_op;
    logic cur_z;
    logic [5:0] legal_ops [9] = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic [2:0] s, input logic [14:0] sb, input logic m);
        exp_st[n_cyc]  = s;
        exp_sb[n_cyc]  = sb;
        exp_ret[n_cyc] = RW'(ret_m);
        tr_mr[n_cyc]   = m;
        tr_op[n_cyc]   = cur_op;
        tr_z[n_cyc]    = cur_z;
        n_cyc++;
    endtask

    task automatic retire();
        ret_m = (ret_m + 1) % (1 << RW);
    endtask

    task automatic trap_tail();
        for (int i = 0; i < 4; i++) add(3'd5, TRP, rb());
    endtask

    // One instruction: fw stall cycles in fetch, mw stall cycles in memory.
    task automatic model_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
        logic [14:0] ms;
        cur_op = o;
        cur_z  = z;
        for (int i = 0; i < fw && i < T; i++) add(3'd0, MRD, 1'b0);
        if (fw >= T) begin trap_tail(); return; end
        add(3'd0, MRD | IRW | PCW, 1'b1);
        if (!(o inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW})) begin
            add(3'd1, 15'h0, rb());
            trap_tail();
            return;
        end
        if (o == OP_J) begin
            add(3'd1, PCW | PCS2, rb());
            retire();
            return;
        end
        add(3'd1, 15'h0, rb());
        if (o == OP_BEQ || o == OP_BNE) begin
            add(3'd2, AOP1 | PCS1 | (((o == OP_BEQ) == z) ? PCW : 15'h0), rb());
            retire();
            return;
        end
        if (o == OP_LW || o == OP_SW) begin
            add(3'd2, ASRC | EXT, rb());
            ms = IOD | ((o == OP_LW) ? MRD : MWR);
            for (int i = 0; i < mw && i < T; i++) add(3'd3, ms, 1'b0);
            if (mw >= T) begin trap_tail(); return; end
            add(3'd3, ms, 1'b1);
            if (o == OP_SW) begin retire(); return; end
        end else if (o == OP_R) begin
            add(3'd2, AOP2, rb());
        end else begin
            add(3'd2, ASRC | AOP3, rb());
        end
        add(3'd4, RWR | ((o == OP_R) ? RDST : 15'h0) | ((o == OP_LW) ? M2R : 15'h0), rb());
        retire();
    endtask

    // drives the first n trace cycles; entered and left on a falling edge
    task automatic apply_trace(input int n);
        for (int i = 0; i < n; i++) begin
            op        = tr_op[i];
            zero      = tr_z[i];
            mem_ready = tr_mr[i];
            #1;
            obs_st[i]  = state;
            obs_sb[i]  = obs_vec;
            obs_ret[i] = retired;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ret_m = 0;
        n_cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; op = OP_J; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (obs_vec !== 15'h0) begin bad++; $display("FAIL reset_strobes got=%h want=%h", obs_vec, 15'h0); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (retired !== '0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
        rst = 1'b0;
        #1;
        total++; if (obs_vec !== (MRD | IRW | PCW)) begin bad++; $display("FAIL reset_release got=%h want=%h", obs_vec, MRD | IRW | PCW); end
        @(negedge clk);
    endtask

    task automatic test_rtype();
        do_reset();
        model_instr(OP_R, 1'b0, 0, 0);
        model_instr(OP_ANDI, 1'b1, 1, 0);
        apply_trace(n_cyc);
        for (int i = 0; i < n_cyc; i++) begin
            total++;
            if ({obs_st[i], obs_sb[i], obs_ret[i]} !== {exp_st[i], exp_sb[i], exp_ret[i]}) begin
                bad++;
                $display("FAIL rtype cyc%0d got st=%0d sb=%h ret=%0d want st=%0d sb=%h ret=%0d",
                         i, obs_st[i], obs_sb[i], obs_ret[i], exp_st[i], exp_sb[i], exp_ret[i]);
            end
        end
    endtask

    task automatic test_lw_wait();
        do_reset();
        model_instr(OP_LW, 1'b0, 2, 3);
        model_instr(OP_ORI, 1'b0, 0, 0);
        model_instr(OP_SW, 1'b1, 0, 1);
        apply_trace(n_cyc);
        for (int i = 0; i < n_cyc; i++) begin
            total++;
            if ({obs_st[i], obs_sb[i], obs_ret[i]} !== {exp_st[i], exp_sb[i], exp_ret[i]}) begin
                bad++;
                $display("FAIL lw_wait cyc%0d got st=%0d sb=%h ret=%0d want st=%0d sb=%h ret=%0d",
                         i, obs_st[i], obs_sb[i], obs_ret[i], exp_st[i], exp_sb[i], exp_ret[i]);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        model_instr(OP_BEQ, 1'b1, 0, 0);
        model_instr(OP_BNE, 1'b1, 0, 0);
        model_instr(OP_BEQ, 1'b0, 0, 0);
        model_instr(OP_BNE, 1'b0, 0, 0);
        model_instr(OP_J, 1'b0, 0, 0);
        apply_trace(n_cyc);
        for (int i = 0; i < n_cyc; i++) begin
            total++;
            if ({obs_st[i], obs_sb[i], obs_ret[i]} !== {exp_st[i], exp_sb[i], exp_ret[i]}) begin
                bad++;
                $display("FAIL branch cyc%0d got st=%0d sb=%h ret=%0d want st=%0d sb=%h ret=%0d",
                         i, obs_st[i], obs_sb[i], obs_ret[i], exp_st[i], exp_sb[i], exp_ret[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] o;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            model_instr(OP_XORI, 1'b0, 0, 0);
            if (k == 0) o = 6'h3F;
            else begin
                o = 6'($urandom_range(0, 63));
                while (o inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW})
                    o = 6'($urandom_range(0, 63));
            end
            model_instr(o, 1'b0, 0, 0);
            apply_trace(n_cyc);
            for (int i = 0; i < n_cyc; i++) begin
                total++;
                if ({obs_st[i], obs_sb[i], obs_ret[i]} !== {exp_st[i], exp_sb[i], exp_ret[i]}) begin
                    bad++;
                    $display("FAIL illegal op=%h cyc%0d got st=%0d sb=%h ret=%0d want st=%0d sb=%h ret=%0d",
                             o, i, obs_st[i], obs_sb[i], obs_ret[i], exp_st[i], exp_sb[i], exp_ret[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 3; k++) begin
            do_reset();
            case (k)
                0: model_instr(OP_R, 1'b0, T, 0);          // fetch timeout
                1: begin                                    // ready on the last allowed cycle
                    model_instr(OP_R, 1'b0, T - 1, 0);
                    model_instr(OP_LW, 1'b0, 0, T - 1);
                end
                default: model_instr(OP_SW, 1'b0, 0, T);   // memory timeout
            endcase
            apply_trace(n_cyc);
            for (int i = 0; i < n_cyc; i++) begin
                total++;
                if ({obs_st[i], obs_sb[i], obs_ret[i]} !== {exp_st[i], exp_sb[i], exp_ret[i]}) begin
                    bad++;
                    $display("FAIL timeout%0d cyc%0d got st=%0d sb=%h ret=%0d want st=%0d sb=%h ret=%0d",
                             k, i, obs_st[i], obs_sb[i], obs_ret[i], exp_st[i], exp_sb[i], exp_ret[i]);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        model_instr(OP_R, 1'b0, 0, 0);
        model_instr(OP_R, 1'b0, 0, 0);
        model_instr(OP_SW, 1'b0, 0, 3);
        // stop in the first stalled MEM cycle of the store
        apply_trace(12);
        for (int i = 0; i < 12; i++) begin
            total++;
            if ({obs_st[i], obs_sb[i], obs_ret[i]} !== {exp_st[i], exp_sb[i], exp_ret[i]}) begin
                bad++;
                $display("FAIL rst_mid_pre cyc%0d got st=%0d sb=%h ret=%0d want st=%0d sb=%h ret=%0d",
                         i, obs_st[i], obs_sb[i], obs_ret[i], exp_st[i], exp_sb[i], exp_ret[i]);
            end
        end
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++; if (obs_vec !== 15'h0) begin bad++; $display("FAIL rst_mid_strobes got=%h want=%h", obs_vec, 15'h0); end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_mid_state got=%0d want=0", state); end
        total++; if (retired !== '0) begin bad++; $display("FAIL rst_mid_retired got=%0d want=0", retired); end
        total++; if (obs_vec !== MRD) begin bad++; $display("FAIL rst_mid_fetch got=%h want=%h", obs_vec, MRD); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 150; k++)
            model_instr(legal_ops[$urandom_range(0, 8)], rb(),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0,
                        int'($urandom_range(0, 3)));
        apply_trace(n_cyc);
        for (int i = 0; i < n_cyc; i++) begin
            total++;
            if ({obs_st[i], obs_sb[i], obs_ret[i]} !== {exp_st[i], exp_sb[i], exp_ret[i]}) begin
                bad++;
                $display("FAIL b2b cyc%0d op=%h got st=%0d sb=%h ret=%0d want st=%0d sb=%h ret=%0d",
                         i, tr_op[i], obs_st[i], obs_sb[i], obs_ret[i], exp_st[i], exp_sb[i], exp_ret[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
        n_cyc = 0; ret_m = 0; cur_op = '0; cur_z = 1'b0;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
